// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcodes, sequencer state and width defaults
package risc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG   = 8;

  localparam logic [3:0] OP_ADI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// rtl/lm_sm_sequencer_if.sv - decode-side request and micro-op issue signals of the LM/SM sequencer
interface lm_sm_sequencer_if import risc_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG
);
  localparam int IDX_W = $clog2(NREG);

  logic              instr_valid;
  logic [3:0]        opcode;
  logic [NREG-1:0]   reg_list;
  logic [DATA_W-1:0] base_val;
  logic              stall_in;

  logic              stall_fetch;
  logic              uop_valid;
  logic              uop_is_store;
  logic [IDX_W-1:0]  uop_reg;
  logic [DATA_W-1:0] uop_addr;
  logic              uop_last;
  logic              busy;

  modport master (
    output instr_valid, opcode, reg_list, base_val, stall_in,
    input  stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, uop_last, busy
  );

  modport slave (
    input  instr_valid, opcode, reg_list, base_val, stall_in,
    output stall_fetch, uop_valid, uop_is_store, uop_reg, uop_addr, uop_last, busy
  );

endinterface

// File: rtl/lsb_priority_enc.sv
// rtl/lsb_priority_enc.sv - lowest-set-bit index of a register mask plus exactly-one-bit flag
module lsb_priority_enc #(
  parameter  int NREG  = 8,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_one_hot
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_one_hot = (i_vec != '0) && ((i_vec & (i_vec - NREG'(1))) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - expands one LM/SM instruction into per-register load/store micro-ops
module lm_sm_sequencer import risc_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG
) (
  input logic               clk,
  input logic               reset,
  lm_sm_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NREG);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [NREG-1:0]   r_mask;
  logic [NREG-1:0]   w_mask_nxt;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] w_addr_nxt;
  logic              r_store;
  logic              w_store_nxt;

  logic [IDX_W-1:0]  w_idx;
  logic              w_one_hot;
  logic              w_issue;
  logic              w_accept;
  logic              w_consume;

  lsb_priority_enc #(.NREG(NREG)) u_enc (
    .i_vec     (r_mask),
    .o_idx     (w_idx),
    .o_one_hot (w_one_hot)
  );

  assign w_issue   = (r_state == ST_ISSUE);
  assign w_accept  = !w_issue && bus.instr_valid && is_multi(bus.opcode)
                     && !bus.stall_in && (bus.reg_list != '0);
  assign w_consume = w_issue && !bus.stall_in;

  always_comb begin : next_state
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_addr_nxt  = r_addr;
    w_store_nxt = r_store;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
          w_mask_nxt  = bus.reg_list;
          w_addr_nxt  = bus.base_val;
          w_store_nxt = (bus.opcode == OP_SM);
        end
      end
      ST_ISSUE: begin
        // Clearing the lowest set bit retires exactly the register just issued.
        if (w_consume) begin
          w_mask_nxt = r_mask & (r_mask - NREG'(1));
          w_addr_nxt = r_addr + DATA_W'(1);
          if (w_one_hot) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_addr  <= w_addr_nxt;
      r_store <= w_store_nxt;
    end
  end

  // The address register keeps counting past the last op, so gate it to zero in IDLE.
  always_comb begin : outputs
    bus.uop_valid    = w_issue;
    bus.busy         = w_issue;
    bus.uop_is_store = w_issue & r_store;
    bus.uop_reg      = w_issue ? w_idx : '0;
    bus.uop_addr     = w_issue ? r_addr : '0;
    bus.uop_last     = w_issue & w_one_hot;
    bus.stall_fetch  = w_accept | (w_issue & !(w_one_hot & !bus.stall_in));
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - vector table, corner sequences and queue-model random check of lm_sm_sequencer
module tb_lm_sm_sequencer;
  import risc_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [3:0]  op;
    logic [7:0]  lst;
    logic [15:0] base;
    logic        st_in;
  } in_t;

  typedef struct packed {
    logic        sf;
    logic        v;
    logic        sto;
    logic [2:0]  rg;
    logic [15:0] addr;
    logic        last;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rg;
    logic [15:0] addr;
    logic        sto;
  } uop_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer_if #(.DATA_W(DW), .NREG(NR)) bus ();

  lm_sm_sequencer #(.DATA_W(DW), .NREG(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic in_t vin(input logic iv, input logic [3:0] op, input logic [7:0] lst,
                              input logic [15:0] base, input logic st_in);
    in_t x;
    x.rst = 1'b0; x.iv = iv; x.op = op; x.lst = lst; x.base = base; x.st_in = st_in;
    return x;
  endfunction

  function automatic out_t vout(input logic sf, input logic v, input logic sto, input logic [2:0] rg,
                                input logic [15:0] addr, input logic last, input logic busy);
    out_t o;
    o.sf = sf; o.v = v; o.sto = sto; o.rg = rg; o.addr = addr; o.last = last; o.busy = busy;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("sf=%0b v=%0b st=%0b reg=%0d addr=%04h last=%0b busy=%0b",
                     o.sf, o.v, o.sto, o.rg, o.addr, o.last, o.busy);
  endfunction

  task automatic drive(input in_t x);
    reset           = x.rst;
    bus.instr_valid = x.iv;
    bus.opcode      = x.op;
    bus.reg_list    = x.lst;
    bus.base_val    = x.base;
    bus.stall_in    = x.st_in;
  endtask

  function automatic out_t sample();
    return vout(bus.stall_fetch, bus.uop_valid, bus.uop_is_store, bus.uop_reg,
                bus.uop_addr, bus.uop_last, bus.busy);
  endfunction

  task automatic check(input string nm, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s want %s", nm, fmt(act), fmt(exp));
    end
  endtask

  // Drive at the falling edge, compare 1 ns later, then let the rising edge happen.
  task automatic cycle(input in_t x, input string nm, input out_t exp);
    drive(x);
    #1;
    check(nm, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_t x;
    x = vin(1'b0, OP_ADD, 8'h00, 16'h0000, 1'b0);
    x.rst = 1'b1;
    drive(x);
    @(negedge clk);
  endtask

  vec_t vecs[$];
  uop_t q[$];

  initial begin
    in_t  x;
    out_t e;
    logic [15:0] a;
    logic acc;

    do_reset();
    cycle(vin(1'b0, OP_ADD, 8'h00, 16'h0000, 1'b0), "reset_state", '0);

    // LM 0x05 @0x0100
    vecs.push_back('{vin(1, OP_LM,  8'h05, 16'h0100, 0), vout(1, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_LM,  8'h05, 16'h0100, 0), vout(1, 1, 0, 0, 16'h0100, 0, 1)});
    vecs.push_back('{vin(1, OP_LM,  8'h05, 16'h0100, 0), vout(0, 1, 0, 2, 16'h0101, 1, 1)});
    vecs.push_back('{vin(1, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    // LM 0x81 with two stall cycles on the first op
    vecs.push_back('{vin(1, OP_LM,  8'h81, 16'h0200, 0), vout(1, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_LM,  8'h81, 16'h0200, 1), vout(1, 1, 0, 0, 16'h0200, 0, 1)});
    vecs.push_back('{vin(1, OP_LM,  8'h81, 16'h0200, 1), vout(1, 1, 0, 0, 16'h0200, 0, 1)});
    vecs.push_back('{vin(1, OP_LM,  8'h81, 16'h0200, 0), vout(1, 1, 0, 0, 16'h0200, 0, 1)});
    vecs.push_back('{vin(1, OP_LM,  8'h81, 16'h0200, 0), vout(0, 1, 0, 7, 16'h0201, 1, 1)});
    vecs.push_back('{vin(0, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    // SM 0x03 (stall on last op) then LM 0x10 waiting in decode
    vecs.push_back('{vin(1, OP_SM,  8'h03, 16'h0300, 0), vout(1, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_SM,  8'h03, 16'h0300, 0), vout(1, 1, 1, 0, 16'h0300, 0, 1)});
    vecs.push_back('{vin(1, OP_SM,  8'h03, 16'h0300, 1), vout(1, 1, 1, 1, 16'h0301, 1, 1)});
    vecs.push_back('{vin(1, OP_SM,  8'h03, 16'h0300, 0), vout(0, 1, 1, 1, 16'h0301, 1, 1)});
    vecs.push_back('{vin(1, OP_LM,  8'h10, 16'h0400, 0), vout(1, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_LM,  8'h10, 16'h0400, 0), vout(0, 1, 0, 4, 16'h0400, 1, 1)});
    vecs.push_back('{vin(0, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    // Accept held off by stall_in while IDLE
    vecs.push_back('{vin(1, OP_LM,  8'h01, 16'h0500, 1), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_LM,  8'h01, 16'h0500, 0), vout(1, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(0, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 1, 0, 0, 16'h0500, 1, 1)});
    vecs.push_back('{vin(0, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    // Empty list, then ADD; non-multi opcodes are ignored
    vecs.push_back('{vin(1, OP_LM,  8'h00, 16'h1234, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_ADD, 8'h00, 16'h0000, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, OP_LW,  8'hFF, 16'h2222, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(1, 4'hE,   8'hFF, 16'h2222, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});
    vecs.push_back('{vin(0, OP_SM,  8'hFF, 16'h2222, 0), vout(0, 0, 0, 0, 16'h0000, 0, 0)});

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].in, $sformatf("vec%0d", i), vecs[i].exp);
    end

    // SM 0xFF with address wrap through 0xFFFF
    cycle(vin(1, OP_SM, 8'hFF, 16'hFFFE, 0), "wrap_accept", vout(1, 0, 0, 0, 16'h0000, 0, 0));
    for (int k = 0; k < 8; k++) begin
      a = 16'hFFFE + 16'(k);
      cycle(vin(1, OP_SM, 8'hFF, 16'hFFFE, 0), $sformatf("wrap_uop%0d", k),
            vout(k != 7, 1, 1, 3'(k), a, k == 7, 1));
    end
    cycle(vin(0, OP_ADD, 8'h00, 16'h0000, 0), "wrap_done", '0);

    // Reset after the 2nd of 4 ops, then a fresh LM 0x02
    cycle(vin(1, OP_LM, 8'h0F, 16'h0700, 0), "rst_accept", vout(1, 0, 0, 0, 16'h0000, 0, 0));
    cycle(vin(1, OP_LM, 8'h0F, 16'h0700, 0), "rst_uop0", vout(1, 1, 0, 0, 16'h0700, 0, 1));
    cycle(vin(1, OP_LM, 8'h0F, 16'h0700, 0), "rst_uop1", vout(1, 1, 0, 1, 16'h0701, 0, 1));
    x = vin(1, OP_LM, 8'h0F, 16'h0700, 0);
    x.rst = 1'b1;
    cycle(x, "rst_cycle", vout(1, 1, 0, 2, 16'h0702, 0, 1));
    cycle(vin(0, OP_ADD, 8'h00, 16'h0000, 0), "rst_after", '0);
    cycle(vin(1, OP_LM, 8'h02, 16'h0900, 0), "rst_fresh_acc", vout(1, 0, 0, 0, 16'h0000, 0, 0));
    cycle(vin(0, OP_ADD, 8'h00, 16'h0000, 0), "rst_fresh_uop", vout(0, 1, 0, 1, 16'h0900, 1, 1));
    cycle(vin(0, OP_ADD, 8'h00, 16'h0000, 0), "rst_fresh_done", '0);

    // Random traffic against a queue-of-pending-micro-ops model
    do_reset();
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      x.rst   = ($urandom_range(0, 49) == 0);
      x.iv    = ($urandom_range(0, 3) != 0);
      x.op    = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? OP_SM : OP_LM)
                                             : 4'($urandom_range(0, 15));
      x.lst   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      x.base  = 16'($urandom);
      x.st_in = ($urandom_range(0, 3) == 0);

      acc = (q.size() == 0) && x.iv && (x.op == OP_LM || x.op == OP_SM) && !x.st_in && (x.lst != 8'h00);
      if (q.size() > 0) begin
        e = vout(!(q.size() == 1 && !x.st_in), 1'b1, q[0].sto, q[0].rg, q[0].addr, q.size() == 1, 1'b1);
      end else begin
        e = vout(acc, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      end
      cycle(x, $sformatf("rand%0d", n), e);

      if (x.rst) begin
        q.delete();
      end else if (q.size() > 0) begin
        if (!x.st_in) void'(q.pop_front());
      end else if (acc) begin
        a = x.base;
        for (int i = 0; i < NR; i++) begin
          if (x.lst[i]) begin
            q.push_back('{rg: 3'(i), addr: a, sto: (x.op == OP_SM)});
            a = a + 16'd1;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
